seq_multiplier: RTL and testbench

//  Iterative shift-add multiplier, parametrised successor of the combinational

---
 rtl/seq_multiplier.sv | 133 +++++++++++++
 tb/tb_seq_multiplier.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with valid/ready handshakes, one partial product per cycle.
// Define SEQ_MULT_SIGNED_EN to build two's-complement support (sign-magnitude with a FIX cycle).
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);

`ifdef SEQ_MULT_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 last;
    logic                 accept;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = in_valid && (state == IDLE);

`ifdef SEQ_MULT_SIGNED_EN
    logic             fix_en;
    logic             sign;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Magnitudes of the operands; the most negative value maps onto 2^(WIDTH-1) unsigned.
    always_comb begin
        mag_a = a;
        mag_b = b;
        if (is_signed) begin
            if (a[WIDTH-1]) mag_a = (~a) + WIDTH'(1);
            if (b[WIDTH-1]) mag_b = (~b) + WIDTH'(1);
        end
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = CALC;
            CALC: begin
                if (last) begin
`ifdef SEQ_MULT_SIGNED_EN
                    state_next = fix_en ? FIX : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef SEQ_MULT_SIGNED_EN
            FIX:  state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, add one shifted partial product per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            fix_en <= 1'b0;
            sign   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= '0;
                        cnt <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        fix_en <= is_signed;
                        sign   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
                        mcand  <= a;
                        mplier <= b;
`endif
                    end
                end
                CALC: begin
                    if (mplier[cnt])
                        acc <= acc + ({{WIDTH{1'b0}}, mcand} << cnt);
                    cnt <= last ? '0 : cnt + CW'(1);
                end
`ifdef SEQ_MULT_SIGNED_EN
                FIX: begin
                    if (sign) acc <= (~acc) + (2*WIDTH)'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign product   = acc;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=4) plus a WIDTH=8 random sweep.
// Expected values follow the build: SEQ_MULT_SIGNED_EN selects signed results and FIX latency.
module tb_seq_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [3:0] a, b;
    logic [7:0] product;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int tests_run  = 0;
    int fail_count = 0;
    int done8      = 0;

`ifdef SEQ_MULT_SIGNED_EN
    localparam int SLAT = 5;
    localparam logic [7:0] EXP_M8M8 = 8'd64;
    localparam logic [7:0] EXP_M3P5 = 8'hF1;
    localparam logic [7:0] EXP_M8P7 = 8'hC8;
`else
    localparam int SLAT = 4;
    localparam logic [7:0] EXP_M8M8 = 8'd64;
    localparam logic [7:0] EXP_M3P5 = 8'd65;
    localparam logic [7:0] EXP_M8P7 = 8'd56;
`endif

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(1'b0), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    always @(posedge clk) begin
        if (!rst && out_valid8 && out_ready8) done8 <= done8 + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Offer one operand pair and return the number of edges until out_valid.
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic sv,
                                 output int lat);
        @(negedge clk);
        checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        is_signed = sv;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic runOp(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input logic sv, input logic [7:0] exp_p, input int exp_lat);
        int lat;
        out_ready = 1'b1;
        applyStimulus(av, bv, sv, lat);
        checkOutput({tag, "_lat"}, lat, exp_lat);
        checkOutput({tag, "_prod"}, {24'd0, product}, {24'd0, exp_p});
        @(posedge clk);
        #1 checkOutput({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic runOp8(input int idx);
        logic [15:0] exp_p;
        int lat;
        int stall;
        @(negedge clk);
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        if (idx == 0) begin a8 = 8'd255; b8 = 8'd255; end
        if (idx == 1) begin a8 = 8'd0;   b8 = 8'd0;   end
        exp_p      = 16'(a8) * 16'(b8);
        out_ready8 = 1'b0;
        in_valid8  = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid8 && lat < 30);
        checkOutput("w8_lat", lat, 8);
        checkOutput("w8_prod", {16'd0, product8}, {16'd0, exp_p});
        stall = $urandom_range(0, 3);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1 checkOutput("w8_hold", {16'd0, product8}, {16'd0, exp_p});
        end
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1 out_ready8 = 1'b0;
    endtask

    initial begin
        int lat;
        int rose;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;

        // Reset behaviour
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_product", {24'd0, product}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);

        // Basic unsigned products including extremes
        runOp("u15x15", 4'd15, 4'd15, 1'b0, 8'd225, 4);
        runOp("u0x0", 4'd0, 4'd0, 1'b0, 8'd0, 4);
        runOp("u8x8", 4'd8, 4'd8, 1'b0, 8'd64, 4);

        // Back-pressure: result held, new operands refused
        out_ready = 1'b0;
        applyStimulus(4'd7, 4'd3, 1'b0, lat);
        checkOutput("stall_lat", lat, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 4'd1; b = 4'd1;
            checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_prod", {24'd0, product}, 32'd21);
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_release_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("stall_release_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("stall_release_prod", {24'd0, product}, 32'd21);

        // Signed requests (unsigned interpretation when the feature is not built)
        runOp("s_m8m8", 4'd8, 4'd8, 1'b1, EXP_M8M8, SLAT);
        runOp("s_m3p5", 4'd13, 4'd5, 1'b1, EXP_M3P5, SLAT);
        runOp("s_m8p7", 4'd8, 4'd7, 1'b1, EXP_M8P7, SLAT);
        runOp("s_off_8x8", 4'd8, 4'd8, 1'b0, 8'd64, 4);

        // Reset in the middle of a calculation
        @(negedge clk);
        in_valid = 1'b1; a = 4'd9; b = 4'd9; is_signed = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_product", {24'd0, product}, 32'd0);
        rst = 1'b0;
        rose = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (out_valid) rose++;
        end
        checkOutput("midrst_no_valid", rose, 0);
        runOp("after_rst_2x6", 4'd2, 4'd6, 1'b0, 8'd12, 4);

        // WIDTH=8 random sweep with stalls
        for (int i = 0; i < 300; i++) runOp8(i);
        @(posedge clk);
        #1 checkOutput("w8_completions", done8, 300);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
